digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder.sv | 134 +++++++++++++
 tb/tb_digit_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-wide ripple chain reused over
// WIDTH/DIGIT cycles, with valid/ready handshakes on both sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] digit_sum;
  logic [DIGIT:0]   chain;

  // Ripple chain over the low digit of the operand shift registers.
  always_comb begin
    digit_sum = '0;
    chain     = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      digit_sum[i] = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the incoming borrow is inverted into a carry.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
        carry_d = chain[DIGIT];
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = acc_d;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed vectors, backpressure,
// asynchronous reset mid-operation and random sweeps over several geometries.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_in, b_in;
  logic        cin_in, sub_in;
  logic [4:0]  iv, ordy;
  logic [4:0]  ir, ov, co, of;
  logic [15:0] s0, s1, s2;
  logic [7:0]  s3;
  logic [0:0]  s4;

  int cfg_w [5] = '{16, 16, 16, 8, 1};
  int cfg_d [5] = '{4, 1, 16, 2, 1};

  int errors = 0;
  int checks = 0;

  logic [2:0]  sel;
  logic [15:0] sum_m;
  logic        cout_m, ovf_m, ir_m, ov_m;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[3]), .out_ready(ordy[3]), .sum(s3), .cout(co[3]), .ovf(of[3]));
  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
    .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[4]), .out_ready(ordy[4]), .sum(s4), .cout(co[4]), .ovf(of[4]));

  // Observe one instance at a time through a zero-extended view.
  always_comb begin
    sum_m = '0;
    case (sel)
      3'd0: sum_m = s0;
      3'd1: sum_m = s1;
      3'd2: sum_m = s2;
      3'd3: sum_m = {8'h00, s3};
      3'd4: sum_m = {15'h0000, s4};
      default: sum_m = '0;
    endcase
    cout_m = co[sel];
    ovf_m  = of[sel];
    ir_m   = ir[sel];
    ov_m   = ov[sel];
  end

  // Integer reference: unsigned result for sum/cout, signed result for overflow.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic s,
                                output logic [15:0] rs, output logic rc, output logic ro);
    longint m, ua, ub, sa, sb, r, sr;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      r  = ua + ub + longint'(c);
      rc = (r >= m);
      sr = sa + sb + longint'(c);
    end else begin
      r  = ua - ub - longint'(c);
      rc = (r >= 0);
      sr = sa - sb - longint'(c);
    end
    rs = 16'(r & (m - 1));
    ro = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endfunction

  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic s, input int stall, input string tag);
    int w, n, lat;
    logic [15:0] mask, es;
    logic ec, eo;
    w    = cfg_w[k];
    n    = w / cfg_d[k];
    mask = 16'((longint'(1) << w) - 1);
    sel  = 3'(k);
    model(w, av & mask, bv & mask, c, s, es, ec, eo);
    a_in = av; b_in = bv; cin_in = c; sub_in = s;
    iv[k] = 1'b1;
    checks++;
    if (ir_m !== 1'b1) begin
      errors++; $display("[TB] FAIL %s idle_in_ready: got %b expected 1", tag, ir_m);
    end
    @(posedge clk); #1;
    iv[k]  = 1'b0;
    a_in   = 16'($urandom);
    b_in   = 16'($urandom);
    cin_in = 1'($urandom);
    sub_in = 1'($urandom);
    lat = 0;
    while (ov_m !== 1'b1 && lat < 64) begin
      checks++;
      if (ir_m !== 1'b0) begin
        errors++; $display("[TB] FAIL %s busy_in_ready: got %b expected 0", tag, ir_m);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != n) begin
      errors++; $display("[TB] FAIL %s latency: got %0d expected %0d", tag, lat, n);
    end
    checks++;
    if (sum_m !== es || cout_m !== ec || ovf_m !== eo) begin
      errors++;
      $display("[TB] FAIL %s result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               tag, sum_m, cout_m, ovf_m, es, ec, eo);
    end
    repeat (stall) begin
      @(posedge clk); #1;
      checks++;
      if (ov_m !== 1'b1 || ir_m !== 1'b0 || sum_m !== es || cout_m !== ec || ovf_m !== eo) begin
        errors++;
        $display("[TB] FAIL %s stall_hold: got ov=%b ir=%b sum=%h expected ov=1 ir=0 sum=%h",
                 tag, ov_m, ir_m, sum_m, es);
      end
    end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    checks++;
    if (ov_m !== 1'b0 || ir_m !== 1'b1 || sum_m !== es) begin
      errors++;
      $display("[TB] FAIL %s handshake: got ov=%b ir=%b sum=%h expected ov=0 ir=1 sum=%h",
               tag, ov_m, ir_m, sum_m, es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = '0; ordy = '0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0; sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      sel = 3'(k);
      #1;
      checks++;
      if (ir_m !== 1'b1 || ov_m !== 1'b0 || sum_m !== 16'h0 || cout_m !== 1'b0 || ovf_m !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state[%0d]: got ir=%b ov=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
                 k, ir_m, ov_m, sum_m, cout_m, ovf_m);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005, 16'h8000, 16'h0005};
    logic [15:0] tb [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0005};
    logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] xs [7] = '{16'h5555, 16'h0000, 16'h8000, 16'h0001, 16'hFFFE, 16'h7FFF, 16'hFFFF};
    logic        xc [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        xo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(0, ta[i], tb[i], tc[i], ts[i], 0, $sformatf("directed%0d", i));
      checks++;
      if (sum_m !== xs[i] || cout_m !== xc[i] || ovf_m !== xo[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_const: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum_m, cout_m, ovf_m, xs[i], xc[i], xo[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    sel = 3'd0;
    a_in = 16'h1234; b_in = 16'h4321; cin_in = 1'b0; sub_in = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    guard = 0;
    while (ov_m !== 1'b1 && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (ov_m !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_complete: got out_valid=%b expected 1", ov_m);
    end
    for (int i = 0; i < 10; i++) begin
      iv[0] = ~iv[0];
      a_in  = 16'($urandom);
      b_in  = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (sum_m !== 16'h5555 || cout_m !== 1'b0 || ovf_m !== 1'b0 || ir_m !== 1'b0 || ov_m !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got sum=%h cout=%b ovf=%b ir=%b ov=%b expected 5555 0 0 0 1",
                 i, sum_m, cout_m, ovf_m, ir_m, ov_m);
      end
    end
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    iv[0] = 1'b0;
    checks++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0 || sum_m !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL bp_release: got ir=%b ov=%b sum=%h expected 1 0 5555", ir_m, ov_m, sum_m);
    end
    @(posedge clk); #1;
    checks++;
    if (ir_m !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_no_accept: got in_ready=%b expected 1", ir_m);
    end
  endtask

  task automatic test_reset_mid_op();
    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, "pre_reset");
    sel = 3'd0;
    a_in = 16'hABCD; b_in = 16'h1111; cin_in = 1'b1; sub_in = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0 || sum_m !== 16'h0 || cout_m !== 1'b0 || ovf_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got ir=%b ov=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
               ir_m, ov_m, sum_m, cout_m, ovf_m);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset: got ir=%b ov=%b expected 1 0", ir_m, ov_m);
    end
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1, "after_reset");
    checks++;
    if (sum_m !== 16'h0100) begin
      errors++; $display("[TB] FAIL after_reset_const: got sum=%h expected 0100", sum_m);
    end
  endtask

  task automatic test_sweep(input int k, input int ops);
    for (int i = 0; i < ops; i++) begin
      do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), $sformatf("sweep_w%0d_d%0d_op%0d", cfg_w[k], cfg_d[k], i));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_sweep(0, 200);
    test_sweep(1, 1000);
    test_sweep(2, 1000);
    test_sweep(3, 1000);
    test_sweep(4, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
